// File: rtl/bus_pkg.sv
// Shared types and helpers for the multi-master system bus: arbiter state
// encoding, default widths and a width helper used for index registers.
package bus_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of 1 so single-entry indices still get a bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with lock-while-requesting ownership.
// Optional watchdog (BUS_TIMEOUT_EN) forcibly releases an owner after TIMEOUT_CYC cycles.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] m_req,
    output logic [NUM_M-1:0] m_grant
`ifdef BUS_TIMEOUT_EN
    ,
    output logic [NUM_M-1:0] m_timeout
`endif
);

    localparam int PTR_W = clog2(NUM_M);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [NUM_M-1:0] r_grant;
    logic [NUM_M-1:0] w_grant_next;
    logic [NUM_M-1:0] w_eligible;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W-1:0] w_pick;
    logic             w_found;
    logic             w_owner_req;
    logic             w_expire;

    assign w_owner_req = |(r_grant & m_req);
    assign m_grant     = r_grant;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [NUM_M-1:0] r_blocked;
    logic [NUM_M-1:0] r_timeout;
    logic [NUM_M-1:0] w_expire_mask;

    assign w_expire      = (r_state == ST_OWNED) && w_owner_req &&
                           (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_expire_mask = w_expire ? r_grant : '0;
    // An expired owner stays barred until it lets go of its request.
    assign w_eligible    = m_req & ~r_blocked & ~w_expire_mask;
    assign m_timeout     = r_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_blocked <= '0;
            r_timeout <= '0;
        end else begin
            r_blocked <= (r_blocked | w_expire_mask) & m_req;
            r_timeout <= w_expire_mask;
            if (w_grant_next != r_grant) begin
                r_cnt <= '0;
            end else if (r_state == ST_OWNED) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign w_expire   = 1'b0;
    assign w_eligible = m_req;
`endif

    // Scan upward from the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int i = 1; i <= NUM_M; i++) begin
            if (!w_found && w_eligible[(int'(r_ptr) + i) % NUM_M]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'((int'(r_ptr) + i) % NUM_M);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_OWNED;
                    w_grant_next = NUM_M'(1) << w_pick;
                    w_ptr_next   = w_pick;
                end
            end
            ST_OWNED: begin
                if (!w_owner_req || w_expire) begin
                    if (w_found) begin
                        w_grant_next = NUM_M'(1) << w_pick;
                        w_ptr_next   = w_pick;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_grant_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= PTR_W'(NUM_M - 1);
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_ptr   <= w_ptr_next;
        end
    end

endmodule

// File: rtl/multi_master_bus.sv
// Shared multi-master bus: address decode, forwarding, registered read return
// and decode-error pulse. Define BUS_TIMEOUT_EN to enable the ownership watchdog.
module multi_master_bus
    import bus_pkg::*;
#(
    parameter int                      NUM_M       = 2,
    parameter int                      NUM_S       = 2,
    parameter int                      ADDR_W      = DEF_ADDR_W,
    parameter int                      DATA_W      = DEF_DATA_W,
    parameter int                      WIN_BITS    = 12,
    parameter logic [NUM_S*ADDR_W-1:0] S_BASE      = {16'h7000, 16'h0000},
    parameter int                      TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_M-1:0]        m_req,
    input  logic [NUM_M-1:0]        m_wr,
    input  logic [NUM_M*ADDR_W-1:0] m_addr,
    input  logic [NUM_M*DATA_W-1:0] m_dout,
    output logic [NUM_M-1:0]        m_grant,
    output logic [DATA_W-1:0]       m_din,
    output logic [NUM_S-1:0]        s_sel,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_din,
    output logic                    s_wr,
    input  logic [NUM_S*DATA_W-1:0] s_dout,
    output logic                    dec_err
`ifdef BUS_TIMEOUT_EN
    ,
    output logic [NUM_M-1:0]        m_timeout
`endif
);

    localparam int MIDX_W = clog2(NUM_M);
    localparam int SIDX_W = clog2(NUM_S);
    localparam int TAG_W  = ADDR_W - WIN_BITS;

    logic [MIDX_W-1:0] w_owner;
    logic              w_owned;
    logic              w_owner_req;
    logic              w_owner_wr;
    logic              w_active;
    logic              w_hit;
    logic [ADDR_W-1:0] w_owner_addr;
    logic [DATA_W-1:0] w_owner_dout;
    logic [NUM_S-1:0]  w_match;
    logic [SIDX_W-1:0] w_hit_idx;
    logic              r_rd_valid;
    logic              r_rd_wr;
    logic [SIDX_W-1:0] r_rd_idx;
    logic              r_dec_err;

    bus_rr_arbiter #(
        .NUM_M       (NUM_M),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_req     (m_req),
        .m_grant   (m_grant)
`ifdef BUS_TIMEOUT_EN
        ,
        .m_timeout (m_timeout)
`endif
    );

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (m_grant[i]) begin
                w_owner = MIDX_W'(i);
            end
        end
    end

    assign w_owned      = |m_grant;
    assign w_owner_req  = m_req[w_owner];
    assign w_owner_wr   = m_wr[w_owner];
    assign w_owner_addr = m_addr[w_owner*ADDR_W +: ADDR_W];
    assign w_owner_dout = m_dout[w_owner*DATA_W +: DATA_W];
    assign w_active     = w_owned & w_owner_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_S; gi++) begin : g_match
            assign w_match[gi] = (w_owner_addr[ADDR_W-1:WIN_BITS] ==
                                  S_BASE[gi*ADDR_W+WIN_BITS +: TAG_W]);
        end
    endgenerate

    // Walk downward so the lowest-numbered overlapping window wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = NUM_S - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_hit     = 1'b1;
                w_hit_idx = SIDX_W'(k);
            end
        end
    end

    assign s_sel  = (w_active && w_hit) ? (NUM_S'(1) << w_hit_idx) : '0;
    assign s_wr   = w_active & w_hit & w_owner_wr;
    assign s_addr = w_owned ? w_owner_addr : '0;
    assign s_din  = w_owned ? w_owner_dout : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_wr    <= 1'b0;
            r_rd_idx   <= '0;
            r_dec_err  <= 1'b0;
        end else begin
            r_rd_valid <= w_active & w_hit;
            r_rd_wr    <= w_owner_wr;
            r_rd_idx   <= w_hit_idx;
            r_dec_err  <= w_active & ~w_hit;
        end
    end

    assign m_din   = (r_rd_valid && !r_rd_wr) ? s_dout[r_rd_idx*DATA_W +: DATA_W] : '0;
    assign dec_err = r_dec_err;

endmodule

// File: tb/tb_multi_master_bus.sv
// Bench for multi_master_bus: directed table, hand sequences for arbitration
// hand-off and reset, and random traffic against a transaction-level model.
module tb_multi_master_bus;

    localparam int NUM_M       = 2;
    localparam int NUM_S       = 2;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 64;
    localparam int WIN_BITS    = 12;
    localparam int TIMEOUT_CYC = 16;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_M-1:0]        m_req = '0;
    logic [NUM_M-1:0]        m_wr = '0;
    logic [NUM_M*ADDR_W-1:0] m_addr = '0;
    logic [NUM_M*DATA_W-1:0] m_dout = '0;
    logic [NUM_M-1:0]        m_grant;
    logic [DATA_W-1:0]       m_din;
    logic [NUM_S-1:0]        s_sel;
    logic [ADDR_W-1:0]       s_addr;
    logic [DATA_W-1:0]       s_din;
    logic                    s_wr;
    logic [NUM_S*DATA_W-1:0] s_dout = '0;
    logic                    dec_err;
`ifdef BUS_TIMEOUT_EN
    logic [NUM_M-1:0]        m_timeout;
`endif

    multi_master_bus #(
        .NUM_M       (NUM_M),
        .NUM_S       (NUM_S),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WIN_BITS    (WIN_BITS),
        .S_BASE      ({16'h7000, 16'h0000}),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din),
        .s_sel     (s_sel),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_wr      (s_wr),
        .s_dout    (s_dout),
        .dec_err   (dec_err)
`ifdef BUS_TIMEOUT_EN
        ,
        .m_timeout (m_timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: who owns the bus, whose turn is next,
    // which slave's data is due back, and whether an error is due.
    int               mdl_owner;
    int               mdl_last;
    int               mdl_rd_slave;
    int               mdl_held;
    bit               mdl_err;
    bit [NUM_M-1:0]   mdl_blocked;
    bit [NUM_M-1:0]   mdl_tmo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int slave_of(input logic [15:0] a);
        int lo;
        for (int k = 0; k < NUM_S; k++) begin
            lo = (k == 0) ? 'h0000 : 'h7000;
            if (int'(a) >= lo && int'(a) < lo + (1 << WIN_BITS)) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mdl_owner    = -1;
        mdl_last     = NUM_M - 1;
        mdl_rd_slave = -1;
        mdl_held     = 0;
        mdl_err      = 0;
        mdl_blocked  = '0;
        mdl_tmo      = '0;
    endtask

    task automatic check_model(input string tag);
        logic [63:0] e_grant, e_sel, e_wr, e_addr, e_din, e_mdin;
        int          sl;
        bit          active;
        active  = (mdl_owner >= 0) && m_req[mdl_owner];
        sl      = (mdl_owner >= 0) ? slave_of(m_addr[mdl_owner*ADDR_W +: ADDR_W]) : -1;
        e_grant = (mdl_owner >= 0) ? (64'd1 << mdl_owner) : 64'd0;
        e_sel   = (active && sl >= 0) ? (64'd1 << sl) : 64'd0;
        e_wr    = {63'd0, active && sl >= 0 && m_wr[mdl_owner]};
        e_addr  = (mdl_owner >= 0) ? 64'(m_addr[mdl_owner*ADDR_W +: ADDR_W]) : 64'd0;
        e_din   = (mdl_owner >= 0) ? m_dout[mdl_owner*DATA_W +: DATA_W] : 64'd0;
        e_mdin  = (mdl_rd_slave >= 0) ? s_dout[mdl_rd_slave*DATA_W +: DATA_W] : 64'd0;
        chk({tag, ".grant"},   64'(m_grant), e_grant);
        chk({tag, ".s_sel"},   64'(s_sel),   e_sel);
        chk({tag, ".s_wr"},    64'(s_wr),    e_wr);
        chk({tag, ".s_addr"},  64'(s_addr),  e_addr);
        chk({tag, ".s_din"},   s_din,        e_din);
        chk({tag, ".m_din"},   m_din,        e_mdin);
        chk({tag, ".dec_err"}, 64'(dec_err), 64'(mdl_err));
`ifdef BUS_TIMEOUT_EN
        chk({tag, ".m_timeout"}, 64'(m_timeout), 64'(mdl_tmo));
`endif
    endtask

    // Apply the bus rules for one clock edge using the inputs now driven.
    task automatic model_advance();
        int sl, cand;
        bit active, forced;
        active       = (mdl_owner >= 0) && m_req[mdl_owner];
        sl           = (mdl_owner >= 0) ? slave_of(m_addr[mdl_owner*ADDR_W +: ADDR_W]) : -1;
        mdl_rd_slave = (active && sl >= 0 && !m_wr[mdl_owner]) ? sl : -1;
        mdl_err      = active && (sl < 0);
        mdl_tmo      = '0;
        forced       = 0;
        if (active) begin
            mdl_held++;
`ifdef BUS_TIMEOUT_EN
            if (mdl_held >= TIMEOUT_CYC) forced = 1;
`endif
        end
        if (forced) begin
            mdl_tmo[mdl_owner]     = 1'b1;
            mdl_blocked[mdl_owner] = 1'b1;
        end
        if (!active || forced) begin
            cand = -1;
            for (int i = 1; i <= NUM_M; i++) begin
                int c;
                c = (mdl_last + i) % NUM_M;
                if (cand < 0 && m_req[c] && !mdl_blocked[c]) cand = c;
            end
            mdl_owner = cand;
            if (cand >= 0) mdl_last = cand;
            mdl_held = 0;
        end
        mdl_blocked = mdl_blocked & m_req;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        m_req   = '0;
        m_wr    = '0;
        m_addr  = '0;
        m_dout  = '0;
        s_dout  = '0;
        model_reset();
        @(posedge clk);
        #3;
        check_model("reset");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [63:0] dout;
        logic [63:0] s0;
        logic [63:0] s1;
        logic [1:0]  e_sel;
        logic        e_wr;
        logic [63:0] e_mdin;
        logic        e_err;
    } vec_t;

    vec_t       tbl[8];
    logic [1:0] alt_req[7];
    logic [1:0] alt_grant[7];

    initial begin
        tbl[0] = '{16'h00DF, 1'b1, 64'd7,    64'd0,   64'd0,   2'b01, 1'b1, 64'd0,   1'b0};
        tbl[1] = '{16'h00DF, 1'b0, 64'd7,    64'd126, 64'd0,   2'b01, 1'b0, 64'd126, 1'b0};
        tbl[2] = '{16'h7000, 1'b0, 64'd0,    64'd0,   64'd987, 2'b10, 1'b0, 64'd987, 1'b0};
        tbl[3] = '{16'h71FF, 1'b0, 64'd0,    64'd0,   64'd987, 2'b10, 1'b0, 64'd987, 1'b0};
        tbl[4] = '{16'hFFFF, 1'b1, 64'h55,   64'd1,   64'd2,   2'b00, 1'b0, 64'd0,   1'b1};
        tbl[5] = '{16'h0FFF, 1'b0, 64'd0,    64'd5,   64'd9,   2'b01, 1'b0, 64'd5,   1'b0};
        tbl[6] = '{16'h1000, 1'b0, 64'd0,    64'd5,   64'd9,   2'b00, 1'b0, 64'd0,   1'b1};
        tbl[7] = '{16'h7FFF, 1'b1, 64'hAB,   64'd3,   64'd4,   2'b10, 1'b1, 64'd0,   1'b0};
        alt_req   = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11};
        alt_grant = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

        // Requests held during reset must not produce a grant.
        model_reset();
        m_req = 2'b11;
        #2;
        chk("in_reset.grant", 64'(m_grant), 64'd0);
        @(posedge clk);
        #3;
        chk("in_reset_edge.grant", 64'(m_grant), 64'd0);
        chk("in_reset_edge.m_din", m_din, 64'd0);
        apply_reset();

        // First request: master 0 wins one edge later.
        m_req = 2'b01;
        #2;
        chk("first_req.pre_grant", 64'(m_grant), 64'd0);
        tick();
        #2;
        chk("first_req.grant", 64'(m_grant), 64'd1);

        for (int i = 0; i < 8; i++) begin
            m_addr[15:0]  = tbl[i].addr;
            m_wr[0]       = tbl[i].wr;
            m_dout[63:0]  = tbl[i].dout;
            s_dout        = {tbl[i].s1, tbl[i].s0};
            #2;
            chk($sformatf("tbl%0d.s_sel", i), 64'(s_sel), 64'(tbl[i].e_sel));
            chk($sformatf("tbl%0d.s_wr", i),  64'(s_wr),  64'(tbl[i].e_wr));
            chk($sformatf("tbl%0d.s_din", i), s_din,      tbl[i].dout);
            check_model($sformatf("tbl%0d", i));
            tick();
            #2;
            chk($sformatf("tbl%0d.m_din", i),   m_din,        tbl[i].e_mdin);
            chk($sformatf("tbl%0d.dec_err", i), 64'(dec_err), 64'(tbl[i].e_err));
        end

        // Hand-off between two busy masters with no idle cycle.
        m_addr[31:16] = 16'h7010;
        m_wr          = 2'b00;
        m_addr[15:0]  = 16'h0020;
        for (int i = 0; i < 7; i++) begin
            m_req = alt_req[i];
            #2;
            check_model($sformatf("alt%0d", i));
            tick();
            #2;
            chk($sformatf("alt%0d.grant", i), 64'(m_grant), 64'(alt_grant[i]));
        end

`ifdef BUS_TIMEOUT_EN
        apply_reset();
        m_req         = 2'b11;
        m_addr[15:0]  = 16'h0040;
        m_addr[31:16] = 16'h7040;
        tick();
        for (int c = 0; c < TIMEOUT_CYC; c++) begin
            #2;
            chk($sformatf("wdog%0d.grant", c),   64'(m_grant),   64'd1);
            chk($sformatf("wdog%0d.timeout", c), 64'(m_timeout), 64'd0);
            tick();
        end
        #2;
        chk("wdog_fire.grant",   64'(m_grant),   64'd2);
        chk("wdog_fire.timeout", 64'(m_timeout), 64'd1);
        check_model("wdog_fire");
        tick();
        #2;
        chk("wdog_after.timeout", 64'(m_timeout), 64'd0);
        check_model("wdog_after");
`endif

        // Random traffic against the model.
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_M; i++) begin
                int sel;
                if (m_req[i]) m_req[i] = ($urandom_range(0, 9) < 8);
                else          m_req[i] = ($urandom_range(0, 9) < 4);
                sel = $urandom_range(0, 3);
                if (sel == 0)      m_addr[i*ADDR_W +: ADDR_W] = 16'h0000 | 16'($urandom_range(0, 4095));
                else if (sel == 1) m_addr[i*ADDR_W +: ADDR_W] = 16'h7000 | 16'($urandom_range(0, 4095));
                else if (sel == 2) m_addr[i*ADDR_W +: ADDR_W] = 16'($urandom);
                m_wr[i]                    = 1'($urandom_range(0, 1));
                m_dout[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            end
            s_dout = {$urandom, $urandom, $urandom, $urandom};
            #2;
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        // Reset in the middle of a write: grant and s_wr drop at once.
        apply_reset();
        m_req         = 2'b01;
        m_wr          = 2'b01;
        m_addr[15:0]  = 16'h0010;
        m_dout[63:0]  = 64'h1234;
        tick();
        #2;
        check_model("pre_midrst");
        reset_n = 1'b0;
        #1;
        chk("midrst.grant", 64'(m_grant), 64'd0);
        chk("midrst.s_wr",  64'(s_wr),    64'd0);
        chk("midrst.s_sel", 64'(s_sel),   64'd0);
        apply_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
